// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter and sequencer for the 4:1 mux_gate datapath: drives the mux
// selects, holds each grant for a bounded burst of accepted transfers, then rotates.
module mux_rr_arbiter #(
    parameter int unsigned HOLD_MAX = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       out_ready,
    output logic       sel0,
    output logic       sel1,
    output logic [3:0] gnt,
    output logic       out_valid,
    output logic       busy
);

    localparam int unsigned CW = $clog2(HOLD_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_MAX - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t        state, state_n;
    logic [1:0]    idx, idx_n;
    logic [1:0]    ptr, ptr_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    gnt_n;
    logic          xfer;
    logic          rel;

    // First set request scanning p, p+1, ... with modulo-4 wrap; only called with r != 0.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] cand;
        logic       found;
        rr_pick = p;
        found   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cand = p + 2'(k);
            if (!found && r[cand]) begin
                rr_pick = cand;
                found   = 1'b1;
            end
        end
    endfunction

    assign busy      = (state == GRANT);
    assign sel0      = idx[0];
    assign sel1      = idx[1];
    assign out_valid = busy & req[idx];

    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        ptr_n   = ptr;
        cnt_n   = cnt;
        rel     = 1'b0;
        xfer    = out_valid & out_ready;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_n = GRANT;
                    idx_n   = rr_pick(req, ptr);
                    cnt_n   = '0;
                end
            end
            GRANT: begin
                rel = !req[idx] || (xfer && (cnt == CNT_LAST));
                if (rel) begin
                    // Rearbitrate on the release edge so back-to-back grants have no bubble.
                    ptr_n = idx + 2'd1;
                    cnt_n = '0;
                    if (|req) begin
                        idx_n = rr_pick(req, idx + 2'd1);
                    end else begin
                        state_n = IDLE;
                    end
                end else if (xfer) begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
        gnt_n = (state_n == GRANT) ? (4'b0001 << idx_n) : 4'b0000;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; idx is kept through IDLE so the mux output stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= 2'd0;
            ptr   <= 2'd0;
            cnt   <= '0;
            gnt   <= 4'b0000;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            ptr   <= ptr_n;
            cnt   <= cnt_n;
            gnt   <= gnt_n;
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed self-checking bench for mux_rr_arbiter; one instance with HOLD_MAX=4 and
// one with HOLD_MAX=2 share the stimulus.
module tb_mux_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       out_ready;

    logic       sel0_a, sel1_a, out_valid_a, busy_a;
    logic [3:0] gnt_a;
    logic       sel0_b, sel1_b, out_valid_b, busy_b;
    logic [3:0] gnt_b;

    int checks   = 0;
    int failures = 0;

    mux_rr_arbiter #(.HOLD_MAX(4)) u4 (
        .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
        .sel0(sel0_a), .sel1(sel1_a), .gnt(gnt_a), .out_valid(out_valid_a), .busy(busy_a)
    );

    mux_rr_arbiter #(.HOLD_MAX(2)) u2 (
        .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
        .sel0(sel0_b), .sel1(sel1_b), .gnt(gnt_b), .out_valid(out_valid_b), .busy(busy_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected state of the HOLD_MAX=4 instance: gnt, {sel1,sel0}, busy, out_valid.
    task automatic check_a(input string tag, input logic [3:0] g, input logic [1:0] s,
                           input logic b, input logic v);
        check({tag, ".gnt"}, 32'(gnt_a), 32'(g));
        check({tag, ".sel"}, 32'({sel1_a, sel0_a}), 32'(s));
        check({tag, ".busy"}, 32'(busy_a), 32'(b));
        check({tag, ".valid"}, 32'(out_valid_a), 32'(v));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req       = 4'b0000;
        out_ready = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = 4'b1010;
        out_ready = 1'b1;
        #2;
        check_a("rst_hold", 4'b0000, 2'b00, 1'b0, 1'b0);
        check("rst_hold.b.gnt", 32'(gnt_b), 32'h0);
        step();
        check_a("rst_edge", 4'b0000, 2'b00, 1'b0, 1'b0);
        req = 4'b0000;
        step();
        rst_n = 1'b1;
        step();
        check_a("rst_release", 4'b0000, 2'b00, 1'b0, 1'b0);

        // Single streamer: requester 2 re-wins after each 4-transfer burst with no gap.
        req       = 4'b0100;
        out_ready = 1'b1;
        #1;
        check_a("stream_pre", 4'b0000, 2'b00, 1'b0, 1'b0);
        step();
        check_a("stream_gnt", 4'b0100, 2'b10, 1'b1, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            step();
            check_a($sformatf("stream_burst1_%0d", k), 4'b0100, 2'b10, 1'b1, 1'b1);
        end
        // cnt restarted on the regrant, so 4 more transfers are owed before rotating to 0.
        req = 4'b0101;
        for (int k = 1; k <= 3; k++) begin
            step();
            check_a($sformatf("stream_burst2_%0d", k), 4'b0100, 2'b10, 1'b1, 1'b1);
        end
        step();
        check_a("stream_rotate", 4'b0001, 2'b00, 1'b1, 1'b1);

        // All requesting on the HOLD_MAX=2 instance: 0,0,1,1,2,2,3,3,0.
        do_reset();
        req       = 4'b1111;
        out_ready = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
            check($sformatf("all_gnt_%0d", k), 32'(gnt_b), 32'(4'b0001 << (((k - 1) / 2) % 4)));
            check($sformatf("all_sel_%0d", k), 32'({sel1_b, sel0_b}), 32'(((k - 1) / 2) % 4));
            check($sformatf("all_busy_%0d", k), 32'(busy_b), 32'h1);
        end

        // Backpressure: grant to 1, five stalled cycles, then exactly 4 accepted transfers.
        do_reset();
        req       = 4'b0010;
        out_ready = 1'b0;
        step();
        check_a("bp_gnt", 4'b0010, 2'b01, 1'b1, 1'b1);
        req = 4'b0011;
        for (int k = 1; k <= 5; k++) begin
            step();
            check_a($sformatf("bp_stall_%0d", k), 4'b0010, 2'b01, 1'b1, 1'b1);
        end
        out_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            check_a($sformatf("bp_xfer_%0d", k), 4'b0010, 2'b01, 1'b1, 1'b1);
        end
        step();
        check_a("bp_rotate", 4'b0001, 2'b00, 1'b1, 1'b1);

        // Early drop at index 3 with requester 0 waiting: wraps to 0.
        do_reset();
        req       = 4'b1000;
        out_ready = 1'b1;
        step();
        check_a("drop_gnt3", 4'b1000, 2'b11, 1'b1, 1'b1);
        req = 4'b1001;
        step();
        check_a("drop_xfer", 4'b1000, 2'b11, 1'b1, 1'b1);
        req = 4'b0001;
        #1;
        check_a("drop_valid_low", 4'b1000, 2'b11, 1'b1, 1'b0);
        step();
        check_a("drop_wrap", 4'b0001, 2'b00, 1'b1, 1'b1);

        // Early drop with nobody else waiting: IDLE with sel held at 11.
        do_reset();
        req = 4'b1000;
        step();
        check_a("idle_gnt3", 4'b1000, 2'b11, 1'b1, 1'b1);
        step();
        req = 4'b0000;
        #1;
        check_a("idle_valid_low", 4'b1000, 2'b11, 1'b1, 1'b0);
        step();
        check_a("idle_enter", 4'b0000, 2'b11, 1'b0, 1'b0);
        step();
        check_a("idle_stay", 4'b0000, 2'b11, 1'b0, 1'b0);

        // Async reset mid-burst: ptr is 0 after the release from 3, so req=0100 grants 2.
        req = 4'b0100;
        step();
        check_a("areset_gnt2", 4'b0100, 2'b10, 1'b1, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        check_a("areset_async", 4'b0000, 2'b00, 1'b0, 1'b0);
        req = 4'b1111;
        #1;
        rst_n = 1'b1;
        step();
        check_a("areset_first", 4'b0001, 2'b00, 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
